// File: rtl/pix_wr_ctrl.sv
// Camera-to-RAM write stage: buffers 24-bit pixels in a show-ahead FIFO and streams them
// as Avalon word writes until one frame is stored. Optional macro: PIX_WR_TEST_PATT_EN.
module pix_wr_ctrl #(
    parameter int unsigned FIFO_AW      = 4,
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter int unsigned ADDR_W       = 29,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ram_rdy,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [23:0]       pix_data,
    input  logic              avl_ready,
    output logic              avl_write_req,
    output logic [ADDR_W-1:0] avl_addr,
    output logic [31:0]       wr_data,
    output logic              frame_done,
    output logic              busy,
    output logic              overflow,
    output logic [FIFO_AW:0]  fifo_level
);

    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam int unsigned CNT_W   = $clog2(FRAME_PIXELS + 1);
    localparam int unsigned ENTRY_W = CNT_W + 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN
    } state_e;

    state_e              state_q, state_d;
    logic [ENTRY_W-1:0]  mem_q [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    level_q, level_d, remain;
    logic [CNT_W-1:0]    pix_cnt_q, pix_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         data_q, data_d;
    logic                req_q, req_d, done_q, done_d, busy_q, busy_d, ovf_q, ovf_d;
    logic                start, push_req, push_acc, pop, fifo_full;
    logic [ENTRY_W-1:0]  head_entry;

    // Each FIFO entry carries its frame slot index so a dropped pixel leaves a hole
    // in the address sequence instead of shifting later pixels down.
    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        start     = (state_q == S_IDLE) && frame_start && ram_rdy;
        pop       = (state_q != S_IDLE) && req_q && avl_ready;
        push_req  = (state_q == S_CAPTURE) && pix_valid;
        fifo_full = (level_q == (FIFO_AW + 1)'(DEPTH));
        push_acc  = push_req && (!fifo_full || pop);

        remain    = level_q - (FIFO_AW + 1)'(pop);
        rd_ptr_d  = rd_ptr_q + FIFO_AW'(pop);
        wr_ptr_d  = wr_ptr_q + FIFO_AW'(push_acc);
        level_d   = remain + (FIFO_AW + 1)'(push_acc);
        pix_cnt_d = pix_cnt_q + CNT_W'(push_req);
        ovf_d     = ovf_q | (push_req & ~push_acc);

        // Show-ahead head: bypass the incoming pixel when nothing else remains.
        head_entry = (remain == '0) ? {pix_cnt_q, pix_data} : mem_q[rd_ptr_d];
        wr_cnt_d   = (level_d != '0) ? head_entry[ENTRY_W-1 -: CNT_W] : pix_cnt_d;
        req_d      = (level_d != '0);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_CAPTURE;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    level_d   = '0;
                    pix_cnt_d = '0;
                    wr_cnt_d  = '0;
                    req_d     = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (pix_cnt_d == CNT_W'(FRAME_PIXELS)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DRAIN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Frame complete once every slot is resolved and nothing is left to write.
        if ((state_q != S_IDLE) && (pix_cnt_d == CNT_W'(FRAME_PIXELS)) && (level_d == '0)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
        end

        busy_d = (state_d != S_IDLE);
        addr_d = BASE_ADDR + ADDR_W'(wr_cnt_d);
`ifdef PIX_WR_TEST_PATT_EN
        data_d = {8'h00, addr_d[23:0] ^ 24'hFF_FFFF};
`else
        data_d = (level_d != '0) ? {8'h00, head_entry[23:0]} : data_q;
`endif
    end

    // Control, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pix_cnt_q <= '0;
            wr_cnt_q  <= '0;
            addr_q    <= BASE_ADDR;
            data_q    <= '0;
            req_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pix_cnt_q <= pix_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            req_q     <= req_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
        end
    end

    // FIFO storage needs no reset; occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= {pix_cnt_q, pix_data};
        end
    end

    assign avl_write_req = req_q;
    assign avl_addr      = addr_q;
    assign wr_data       = data_q;
    assign frame_done    = done_q;
    assign busy          = busy_q;
    assign overflow      = ovf_q;
    assign fifo_level    = level_q;

endmodule

// File: doc/pix_wr_ctrl.md
# pix_wr_ctrl

Camera-side write stage between the pixel capture logic and one port of the four-port RAM interface. Accepts 24-bit pixels as they arrive from the camera, buffers them in a small FIFO, and issues Avalon write requests with linearly incrementing addresses until one full frame is stored. It then pulses frame-done so the downstream frame-buffer control can start reading.

## Interface
Parameters:
- FIFO_AW, 4, log2 of FIFO depth (depth 16 words of 24 bits)
- FRAME_PIXELS, 307200, pixels per frame (640x480)
- BASE_ADDR, 29'd0, Avalon word address of pixel 0
- ADDR_W, 29, Avalon address width

Ports:
- clk  in  1  system pixel clock (25.2 MHz); all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ram_rdy  in  1  RAM interface calibrated and ready
- frame_start  in  1  one-cycle pulse at start of a camera frame (VSYNC edge)
- pix_valid  in  1  pix_data valid this cycle; no backpressure possible
- pix_data  in  24  RGB888 pixel
- avl_ready  in  1  RAM port accepts the request this cycle
- avl_write_req  out  1  write request
- avl_addr  out  ADDR_W  word address
- wr_data  out  32  {8'h00, pixel}
- frame_done  out  1  one-cycle pulse after last pixel of frame is accepted by RAM
- busy  out  1  high in CAPTURE or DRAIN
- overflow  out  1  sticky: a pixel was dropped due to full FIFO
- fifo_level  out  FIFO_AW+1  current FIFO occupancy

## Operation
- States: IDLE, CAPTURE, DRAIN.
- IDLE -> CAPTURE: frame_start high and ram_rdy high in the same cycle. Clears the pixel-in counter and the write counter. Resets avl_addr to BASE_ADDR. Clears the FIFO.
- frame_start while ram_rdy is low: ignored. Block stays in IDLE.
- CAPTURE: every pix_valid pushes pix_data into the FIFO and increments the pixel-in counter.
  - After FRAME_PIXELS pixels have been pushed, go to DRAIN. Further pix_valid is ignored and does not set overflow.
- DRAIN: no pushes. When the FIFO is empty and the write counter equals FRAME_PIXELS, pulse frame_done and go to IDLE.
- frame_start in CAPTURE or DRAIN: ignored. The frame completes normally.
- Push when the FIFO is full:
  - If a pop occurs in the same cycle, the push is accepted.
  - Otherwise the pixel is dropped, overflow is set, and the pixel-in counter still increments, so frame length stays tied to the camera.
  - The dropped address slot is not written.
- overflow is cleared only by rst.
- Avalon write side runs in CAPTURE and DRAIN:
  - avl_write_req is high whenever the FIFO is non-empty.
  - wr_data is {8'h00, FIFO head}.
  - avl_addr is BASE_ADDR plus the write counter.
  - A word is accepted when avl_write_req and avl_ready are both high. On acceptance, pop the FIFO and increment the write counter and avl_addr.
  - While avl_write_req is high and avl_ready is low, avl_write_req, avl_addr and wr_data stay stable.
- Address arithmetic is modulo 2^ADDR_W. The write counter width is ceil(log2(FRAME_PIXELS+1)).
- ram_rdy falling mid-frame does not abort the frame. Requests stay pending until avl_ready.
- rst at any time: return to IDLE, empty the FIFO, and apply all output reset values. A partially written frame is abandoned.
- Reset values: avl_write_req 0, avl_addr BASE_ADDR, wr_data 0, frame_done 0, busy 0, overflow 0, fifo_level 0.

## Timing
- FIFO is show-ahead with registered occupancy.
- A pixel pushed in cycle N appears at the FIFO head and raises avl_write_req in cycle N+1 (empty-FIFO latency is 1 cycle).
- Steady state with avl_ready held high: one word accepted per cycle, so the FIFO never exceeds 1 entry.
- frame_done asserts the cycle after the final acceptance and lasts exactly 1 cycle. busy falls in that same cycle.
- The earliest next frame accepted is on the cycle after frame_done.
- fifo_level updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.

## Configuration
- PIX_WR_TEST_PATT_EN defined: wr_data is {8'h00, avl_addr[23:0] ^ 24'hFFFFFF} instead of the pixel. Pixel flow, counting and handshakes are unchanged. This supports RAM bring-up without a camera.
- Undefined: wr_data carries the captured pixel as specified above.

## Test plan
- avl_ready tied high, FRAME_PIXELS=8, BASE_ADDR=29'h100, frame_start then 8 consecutive pix_valid with data 0x000001..0x000008. Expect writes to 0x100..0x107 carrying 0x00000001..0x00000008. frame_done pulses 1 cycle after the 8th acceptance. overflow stays 0.
- avl_ready low for 20 cycles while 16 pixels arrive, then high. Expect fifo_level reaches 16 and no overflow. avl_addr and wr_data stay stable while stalled. The 16 writes then occur in order on consecutive cycles.
- Same as above but with 17 pixels during the stall. Expect overflow=1, the 17th pixel dropped, and its address never written. frame_done still pulses after the remaining writes.
- frame_start with ram_rdy=0. Expect busy stays 0 and no writes. A later frame_start with ram_rdy=1 starts capture at BASE_ADDR.
- rst asserted mid-CAPTURE after 3 writes. Expect next cycle avl_write_req=0, fifo_level=0, avl_addr=BASE_ADDR and IDLE state. A following frame restarts from BASE_ADDR.
- Build with PIX_WR_TEST_PATT_EN, BASE_ADDR=0, 4-pixel frame. Expect wr_data 0x00FFFFFF, 0x00FFFFFE, 0x00FFFFFD, 0x00FFFFFC at addresses 0..3.
